// File: rtl/seq_scroll_display_pkg.sv
// Shared constants and width helper for the scrolling seven-segment driver.
// No clocked logic; imported by the interface, decoder and top.
package seq_display_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Counter/index width that never collapses to zero bits.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_scroll_display_if.sv
// Sequence-in / segment-out bundle of the scrolling display driver.
// master = sequence source and pin observer, slave = the driver itself.
interface seq_scroll_display_if #(
  parameter int N_DIGITS = 8,
  parameter int SEQ_LEN  = 10
);
  localparam int LW = $clog2(SEQ_LEN + 1);
  localparam int PW = seq_display_pkg::width_of(SEQ_LEN);

  logic                  en;
  logic [4*SEQ_LEN-1:0]  seq;
  logic [LW-1:0]         seq_len;
  logic [6:0]            seg;
  logic [N_DIGITS-1:0]   an;
  logic [PW-1:0]         pos;
  logic                  wrap;

  modport master (output en, seq, seq_len, input seg, an, pos, wrap);
  modport slave  (input en, seq, seq_len, output seg, an, pos, wrap);

endinterface

// File: rtl/seq_scroll_display_bcd_7seg.sv
// bcd_7seg: 4-bit code to active-low a..g pattern (bit 0 = a), hex glyphs for 10..15.
// Latency: combinational. Backpressure: none.
module bcd_7seg (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (bcd_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seq_scroll_display.sv
// seq_scroll_display: scans N_DIGITS anodes and scrolls a BCD sequence; SEQ_SCROLL_BLANK_EN blanks code F.
// Latency: seg/an registered 1 clk after scan_tick. Backpressure: none, free-running.
module seq_scroll_display
  import seq_display_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SEQ_LEN  = 10,
  parameter int SCAN_DIV = 100000,
  parameter int STEP_DIV = 100000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_scroll_display_if.slave  bus
);

  localparam int LW    = $clog2(SEQ_LEN + 1);
  localparam int PW    = width_of(SEQ_LEN);
  localparam int SW    = width_of(N_DIGITS);
  localparam int CSW   = width_of(SCAN_DIV);
  localparam int CTW   = width_of(STEP_DIV);
  localparam int IW    = width_of(SEQ_LEN + N_DIGITS) + 1;
  localparam int NSUB  = SEQ_LEN + N_DIGITS;

  logic [CSW-1:0]      scan_cnt_q, scan_cnt_d;
  logic [CTW-1:0]      step_cnt_q, step_cnt_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic                wrap_q, wrap_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic                scan_tick, step_tick;
  logic [LW-1:0]       len_eff;
  logic [IW-1:0]       len_x, pos_x, idx;
  logic [3:0]          digit;
  logic [6:0]          dec_seg, disp_seg;

  assign scan_tick = (scan_cnt_q == CSW'(SCAN_DIV - 1));
  assign step_tick = (step_cnt_q == CTW'(STEP_DIV - 1));
  assign len_eff   = (bus.seq_len > LW'(SEQ_LEN)) ? LW'(SEQ_LEN) : bus.seq_len;
  assign len_x     = IW'(len_eff);
  assign pos_x     = IW'(pos_q);

  // Modulo by repeated conditional subtraction; enough passes to cover L=1.
  always_comb begin
    idx = IW'(pos_q) + IW'(slot_q);
    for (int i = 0; i < NSUB; i++) begin
      if (idx >= len_x) idx = idx - len_x;
    end
  end

  always_comb begin
    digit = 4'h0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (idx == IW'(i)) digit = bus.seq[4*i +: 4];
    end
  end

  bcd_7seg u_dec (
    .bcd_i (digit),
    .seg_o (dec_seg)
  );

`ifdef SEQ_SCROLL_BLANK_EN
  assign disp_seg = (digit == BLANK_CODE) ? SEG_BLANK : dec_seg;
`else
  assign disp_seg = dec_seg;
`endif

  always_comb begin
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 1'b1;
    step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;

    slot_d = slot_q;
    if (scan_tick) slot_d = (slot_q == SW'(N_DIGITS - 1)) ? '0 : slot_q + 1'b1;

    // A shrunk length resets pos silently; only a real L-1 -> 0 step wraps.
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (len_x == '0 || pos_x >= len_x) begin
      pos_d = '0;
    end else if (step_tick && bus.en) begin
      if (pos_x == len_x - 1'b1) begin
        pos_d  = '0;
        wrap_d = 1'b1;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end

    seg_d = seg_q;
    an_d  = an_q;
    if (len_x == '0) begin
      seg_d = SEG_BLANK;
      an_d  = '1;
    end else if (scan_tick) begin
      seg_d = disp_seg;
      an_d  = ~(N_DIGITS'(1) << (SW'(N_DIGITS - 1) - slot_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      step_cnt_q <= '0;
      slot_q     <= '0;
      pos_q      <= '0;
      wrap_q     <= 1'b0;
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      step_cnt_q <= step_cnt_d;
      slot_q     <= slot_d;
      pos_q      <= pos_d;
      wrap_q     <= wrap_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.pos  = pos_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_seq_scroll_display.sv
// Bench for seq_scroll_display: directed steps plus random sequences against a cycle-count reference model.
module tb_seq_scroll_display;

  localparam int N    = 4;
  localparam int SL   = 8;
  localparam int SCAN = 4;
  localparam int STEP = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seq_scroll_display_if #(.N_DIGITS(N), .SEQ_LEN(SL)) bus ();

  seq_scroll_display #(
    .N_DIGITS (N),
    .SEQ_LEN  (SL),
    .SCAN_DIV (SCAN),
    .STEP_DIV (STEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: k = edges since reset release.
  int         k;
  int         m_pos;
  logic       m_wrap;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [6:0] glyph(input logic [3:0] d);
`ifdef SEQ_SCROLL_BLANK_EN
    if (d == 4'hF) return 7'h7F;
`endif
    return glyph_tab[d];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int L, s, d, np;
    logic [3:0] one;
    L   = (int'(bus.seq_len) > SL) ? SL : int'(bus.seq_len);
    one = 4'b0001;
    if (L == 0) begin
      m_an  = 4'hF;
      m_seg = 7'h7F;
    end else if (k % SCAN == SCAN - 1) begin
      s     = (k / SCAN) % N;
      d     = (m_pos + s) % L;
      m_an  = ~(one << (N - 1 - s));
      m_seg = glyph(bus.seq[4*d +: 4]);
    end
    m_wrap = 1'b0;
    if (L == 0 || m_pos >= L) begin
      m_pos = 0;
    end else if (k % STEP == STEP - 1 && bus.en) begin
      np     = (m_pos + 1) % L;
      m_wrap = (np == 0);
      m_pos  = np;
    end
    k++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("seg",  32'(bus.seg),  32'(m_seg));
    check("an",   32'(bus.an),   32'(m_an));
    check("pos",  32'(bus.pos),  32'(m_pos));
    check("wrap", 32'(bus.wrap), 32'(m_wrap));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_seg",  32'(bus.seg),  32'h7F);
    check("rst_an",   32'(bus.an),   32'hF);
    check("rst_pos",  32'(bus.pos),  32'h0);
    check("rst_wrap", 32'(bus.wrap), 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    k      = 0;
    m_pos  = 0;
    m_wrap = 1'b0;
    m_an   = 4'hF;
    m_seg  = 7'h7F;
  endtask

  function automatic logic [31:0] rand_seq();
    return $urandom();
  endfunction

  initial begin
    logic [3:0] an_exp [4] = '{4'h7, 4'hB, 4'hD, 4'hE};
    logic [6:0] f_exp;
    int wraps;

    bus.en      = 1'b0;
    bus.seq     = '0;
    bus.seq_len = '0;
    #2;

    // Plain scan of digits 0..3, no scrolling.
    bus.seq     = {rand_seq() & 32'hFFFF_0000} | 32'h0000_3210;
    bus.seq_len = 4'd4;
    bus.en      = 1'b0;
    do_reset();
    repeat (3) tick();
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        check("scan_an", 32'(bus.an), 32'(an_exp[j]));
        check("scan_seg", 32'(bus.seg), 32'(glyph_tab[j]));
      end
    end

    // Scroll with length 3: seven steps give two wraps and end at pos 1.
    do_reset();
    bus.seq     = rand_seq();
    bus.seq_len = 4'd3;
    bus.en      = 1'b1;
    wraps = 0;
    for (int c = 0; c < 7 * STEP; c++) begin
      tick();
      if (bus.wrap === 1'b1) wraps++;
    end
    check("scroll_wraps", 32'(wraps), 32'd2);
    check("scroll_pos", 32'(bus.pos), 32'd1);

    // Shrink length under a pos of 5.
    do_reset();
    bus.seq     = rand_seq();
    bus.seq_len = 4'd8;
    bus.en      = 1'b1;
    repeat (5 * STEP) tick();
    check("pre_shrink_pos", 32'(bus.pos), 32'd5);
    bus.seq_len = 4'd4;
    tick();
    check("shrink_pos", 32'(bus.pos), 32'd0);
    check("shrink_wrap", 32'(bus.wrap), 32'd0);
    repeat ($urandom_range(1, 40)) tick();

    // Asynchronous reset mid-count, then empty sequence.
    do_reset();
    bus.seq_len = 4'd0;
    bus.en      = 1'($urandom_range(0, 1));
    for (int c = 0; c < 200; c++) begin
      tick();
      check("empty_an", 32'(bus.an), 32'hF);
      check("empty_seg", 32'(bus.seg), 32'h7F);
      check("empty_pos", 32'(bus.pos), 32'h0);
    end

    // Code F in slot 1 of a two-digit sequence.
    do_reset();
    bus.seq     = (rand_seq() & 32'hFFFF_FF0F) | 32'h0000_00F0;
    bus.seq_len = 4'd2;
    bus.en      = 1'b0;
`ifdef SEQ_SCROLL_BLANK_EN
    f_exp = 7'h7F;
`else
    f_exp = 7'h0E;
`endif
    repeat (8) tick();
    check("feat_an", 32'(bus.an), 32'hB);
    check("feat_seg", 32'(bus.seg), 32'(f_exp));

    // Random sequences, lengths (including >SEQ_LEN) and enables.
    for (int r = 0; r < 12; r++) begin
      bus.seq     = rand_seq();
      bus.seq_len = 4'($urandom_range(0, 15));
      bus.en      = 1'($urandom_range(0, 1));
      repeat ($urandom_range(40, 120)) tick();
      bus.seq = rand_seq();
      bus.en  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(20, 80)) tick();
      if (r == 6) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
